// File: rtl/fractal_sync_pkg.sv
// rtl/fractal_sync_pkg.sv - shared types and helpers for the fractal_sync RF arbiter
package fractal_sync_pkg;

   // Default field widths of a synch request as seen by the register file
   localparam int unsigned RF_LEVEL_WIDTH = 1;
   localparam int unsigned RF_ID_WIDTH    = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PEND = 2'd1,
      RSP  = 2'd2
   } rf_arb_state_e;

   typedef struct packed {
      logic [RF_LEVEL_WIDTH-1:0] level;
      logic [RF_ID_WIDTH-1:0]    id;
      logic                      remote;
   } rf_arb_req_t;

   typedef struct packed {
      logic present;
      logic err;
      logic ignore;
      logic timeout;
   } rf_arb_rsp_t;

   // Pointer width that still works for a single requester
   function automatic int unsigned ptr_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fractal_sync_rr_multi_arb.sv
// rtl/fractal_sync_rr_multi_arb.sv - round-robin arbiter handing out up to N_PORTS grants per cycle
module fractal_sync_rr_multi_arb
   import fractal_sync_pkg::*;
#(
   parameter  int unsigned N_REQ   = 4,
   parameter  int unsigned N_PORTS = 2,
   localparam int unsigned PTR_W   = ptr_width(N_REQ)
) (
   input  logic [N_REQ-1:0]                eligible_i,
   input  logic [PTR_W-1:0]                rr_ptr_i,
   output logic [N_PORTS-1:0][N_REQ-1:0]   grant_oh_o,
   output logic [N_PORTS-1:0]              grant_valid_o,
   output logic [PTR_W-1:0]                next_ptr_o
);

   // Scan requesters from rr_ptr with wrap-around; the k-th eligible one found gets port k
   always_comb begin
      int unsigned idx;
      int unsigned cnt;
      int unsigned last;
      grant_oh_o    = '0;
      grant_valid_o = '0;
      next_ptr_o    = rr_ptr_i;
      idx           = 0;
      cnt           = 0;
      last          = 0;
      for (int unsigned off = 0; off < N_REQ; off++) begin
         idx = (32'(rr_ptr_i) + off) % N_REQ;
         for (int unsigned i = 0; i < N_REQ; i++) begin
            if ((i == idx) && eligible_i[i] && (cnt < N_PORTS)) begin
               for (int unsigned k = 0; k < N_PORTS; k++) begin
                  if (k == cnt) begin
                     grant_oh_o[k][i] = 1'b1;
                     grant_valid_o[k] = 1'b1;
                  end
               end
               last = i;
               cnt  = cnt + 1;
            end
         end
      end
      if (cnt != 0) begin
         next_ptr_o = PTR_W'((last + 1) % N_REQ);
      end
   end

endmodule

// File: rtl/fractal_sync_rf_arbiter.sv
// rtl/fractal_sync_rf_arbiter.sv - shares fractal_sync RF check ports between requesters with bypass retry
module fractal_sync_rf_arbiter
   import fractal_sync_pkg::*;
#(
   parameter int unsigned N_REQ       = 4,
   parameter int unsigned N_PORTS     = 2,
   parameter int unsigned LEVEL_WIDTH = 1,
   parameter int unsigned ID_WIDTH    = 1,
   parameter int unsigned MAX_RETRY   = 3
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic [N_REQ-1:0]                    req_valid_i,
   output logic [N_REQ-1:0]                    req_ready_o,
   input  logic [N_REQ-1:0][LEVEL_WIDTH-1:0]   req_level_i,
   input  logic [N_REQ-1:0][ID_WIDTH-1:0]      req_id_i,
   input  logic [N_REQ-1:0]                    req_remote_i,
   output logic [N_REQ-1:0]                    rsp_valid_o,
   input  logic [N_REQ-1:0]                    rsp_ready_i,
   output logic [N_REQ-1:0]                    rsp_present_o,
   output logic [N_REQ-1:0]                    rsp_err_o,
   output logic [N_REQ-1:0]                    rsp_ignore_o,
   output logic [N_REQ-1:0]                    rsp_timeout_o,
   output logic [N_PORTS-1:0][LEVEL_WIDTH-1:0] level_o,
   output logic [N_PORTS-1:0][ID_WIDTH-1:0]    id_o,
   output logic [N_PORTS-1:0]                  check_local_o,
   output logic [N_PORTS-1:0]                  check_remote_o,
   input  logic [N_PORTS-1:0]                  present_local_i,
   input  logic [N_PORTS-1:0]                  present_remote_i,
   input  logic [N_PORTS-1:0]                  id_err_i,
   input  logic [N_PORTS-1:0]                  sig_err_i,
   input  logic [N_PORTS-1:0]                  bypass_local_i,
   input  logic [N_PORTS-1:0]                  bypass_remote_i,
   input  logic [N_PORTS-1:0]                  ignore_local_i,
   input  logic [N_PORTS-1:0]                  ignore_remote_i
);

   localparam int unsigned PTR_W   = ptr_width(N_REQ);
   localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);

   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_PEND = PEND;
   localparam logic [1:0] ST_RSP  = RSP;

   logic [1:0]             state_q  [N_REQ];
   logic [LEVEL_WIDTH-1:0] level_q  [N_REQ];
   logic [ID_WIDTH-1:0]    id_q     [N_REQ];
   logic [N_REQ-1:0]       remote_q;
   logic [RETRY_W-1:0]     retry_q  [N_REQ];
   rf_arb_rsp_t            rsp_q    [N_REQ];
   logic [PTR_W-1:0]       rr_ptr_q;
   logic [PTR_W-1:0]       next_ptr;

   logic [N_REQ-1:0]              eligible;
   logic [N_PORTS-1:0][N_REQ-1:0] grant_oh;
   logic [N_PORTS-1:0]            grant_valid;

   logic [LEVEL_WIDTH-1:0] port_level   [N_PORTS];
   logic [ID_WIDTH-1:0]    port_id      [N_PORTS];
   logic [N_PORTS-1:0]     port_remote;
   logic [N_PORTS-1:0]     port_bypass;
   logic [N_PORTS-1:0]     port_present;
   logic [N_PORTS-1:0]     port_err;
   logic [N_PORTS-1:0]     port_ignore;

   logic [N_REQ-1:0]       granted;
   logic [N_REQ-1:0]       hit_bypass;
   rf_arb_rsp_t            hit_rsp [N_REQ];

   // Only requesters waiting for the RF compete for ports
   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         eligible[i] = (state_q[i] == ST_PEND);
      end
   end

   fractal_sync_rr_multi_arb #(
      .N_REQ   (N_REQ),
      .N_PORTS (N_PORTS)
   ) u_arb (
      .eligible_i    (eligible),
      .rr_ptr_i      (rr_ptr_q),
      .grant_oh_o    (grant_oh),
      .grant_valid_o (grant_valid),
      .next_ptr_o    (next_ptr)
   );

   // Route the granted request onto each port and pick the RF result matching its local/remote side
   always_comb begin
      for (int k = 0; k < N_PORTS; k++) begin
         port_level[k]  = '0;
         port_id[k]     = '0;
         port_remote[k] = 1'b0;
         for (int i = 0; i < N_REQ; i++) begin
            if (grant_oh[k][i]) begin
               port_level[k]  = level_q[i];
               port_id[k]     = id_q[i];
               port_remote[k] = remote_q[i];
            end
         end
         port_bypass[k]  = port_remote[k] ? bypass_remote_i[k]  : bypass_local_i[k];
         port_present[k] = port_remote[k] ? present_remote_i[k] : present_local_i[k];
         port_err[k]     = port_remote[k] ? sig_err_i[k]        : id_err_i[k];
         port_ignore[k]  = port_remote[k] ? ignore_remote_i[k]  : ignore_local_i[k];
         level_o[k]        = rst_i ? '0 : port_level[k];
         id_o[k]           = rst_i ? '0 : port_id[k];
         check_local_o[k]  = ~rst_i & grant_valid[k] & ~port_remote[k];
         check_remote_o[k] = ~rst_i & grant_valid[k] &  port_remote[k];
      end
   end

   // Map each port's outcome back to the requester that owns it this cycle
   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         granted[i]    = 1'b0;
         hit_bypass[i] = 1'b0;
         hit_rsp[i]    = '0;
         for (int k = 0; k < N_PORTS; k++) begin
            if (grant_oh[k][i]) begin
               granted[i]         = 1'b1;
               hit_bypass[i]      = port_bypass[k];
               hit_rsp[i].present = port_present[k];
               hit_rsp[i].err     = port_err[k];
               hit_rsp[i].ignore  = port_ignore[k];
               hit_rsp[i].timeout = 1'b0;
            end
         end
      end
   end

   // Per-requester handshake FSMs, retry counting and round-robin pointer
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_ptr_q <= '0;
         remote_q <= '0;
         for (int i = 0; i < N_REQ; i++) begin
            state_q[i] <= ST_IDLE;
            level_q[i] <= '0;
            id_q[i]    <= '0;
            retry_q[i] <= '0;
            rsp_q[i]   <= '0;
         end
      end else begin
         rr_ptr_q <= next_ptr;
         for (int i = 0; i < N_REQ; i++) begin
            case (state_q[i])
               ST_IDLE: begin
                  if (req_valid_i[i]) begin
                     level_q[i]  <= req_level_i[i];
                     id_q[i]     <= req_id_i[i];
                     remote_q[i] <= req_remote_i[i];
                     retry_q[i]  <= '0;
                     state_q[i]  <= ST_PEND;
                  end
               end
               ST_PEND: begin
                  if (granted[i]) begin
                     if (hit_bypass[i] && (retry_q[i] < RETRY_W'(MAX_RETRY))) begin
                        retry_q[i] <= retry_q[i] + RETRY_W'(1);
                     end else if (hit_bypass[i]) begin
                        rsp_q[i].present <= 1'b0;
                        rsp_q[i].err     <= 1'b1;
                        rsp_q[i].ignore  <= 1'b0;
                        rsp_q[i].timeout <= 1'b1;
                        state_q[i]       <= ST_RSP;
                     end else begin
                        rsp_q[i]   <= hit_rsp[i];
                        state_q[i] <= ST_RSP;
                     end
                  end
               end
               ST_RSP: begin
                  if (rsp_ready_i[i]) begin
                     state_q[i] <= ST_IDLE;
                  end
               end
               default: state_q[i] <= ST_IDLE;
            endcase
         end
      end
   end

   // Handshake outputs; response fields read as zero outside the RSP state
   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         req_ready_o[i]   = (state_q[i] == ST_IDLE);
         rsp_valid_o[i]   = (state_q[i] == ST_RSP);
         rsp_present_o[i] = rsp_valid_o[i] & rsp_q[i].present;
         rsp_err_o[i]     = rsp_valid_o[i] & rsp_q[i].err;
         rsp_ignore_o[i]  = rsp_valid_o[i] & rsp_q[i].ignore;
         rsp_timeout_o[i] = rsp_valid_o[i] & rsp_q[i].timeout;
      end
   end

endmodule

// File: tb/tb_fractal_sync_rf_arbiter.sv
// tb/tb_fractal_sync_rf_arbiter.sv - self-checking bench for fractal_sync_rf_arbiter
module tb_fractal_sync_rf_arbiter;

   localparam int N_REQ   = 4;
   localparam int N_PORTS = 2;

   logic clk = 1'b0;
   logic rst;
   logic [N_REQ-1:0]        req_valid, req_ready, req_remote;
   logic [N_REQ-1:0][0:0]   req_level, req_id;
   logic [N_REQ-1:0]        rsp_valid, rsp_ready, rsp_present, rsp_err, rsp_ignore, rsp_timeout;
   logic [N_PORTS-1:0][0:0] level, id;
   logic [N_PORTS-1:0]      chk_l, chk_r;
   logic [N_PORTS-1:0]      pl, pr, ie, se, bl, br, il, ir;
   logic [7:0]              rf_res;

   // RF stand-in: {present_local, present_remote, id_err, sig_err, bypass_local, bypass_remote, ignore_local, ignore_remote}
   assign pl = {N_PORTS{rf_res[7]}};
   assign pr = {N_PORTS{rf_res[6]}};
   assign ie = {N_PORTS{rf_res[5]}};
   assign se = {N_PORTS{rf_res[4]}};
   assign bl = {N_PORTS{rf_res[3]}};
   assign br = {N_PORTS{rf_res[2]}};
   assign il = {N_PORTS{rf_res[1]}};
   assign ir = {N_PORTS{rf_res[0]}};

   always #5 clk = ~clk;

   fractal_sync_rf_arbiter #(
      .N_REQ(N_REQ), .N_PORTS(N_PORTS), .LEVEL_WIDTH(1), .ID_WIDTH(1), .MAX_RETRY(3)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_level_i(req_level), .req_id_i(req_id), .req_remote_i(req_remote),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
      .rsp_present_o(rsp_present), .rsp_err_o(rsp_err),
      .rsp_ignore_o(rsp_ignore), .rsp_timeout_o(rsp_timeout),
      .level_o(level), .id_o(id), .check_local_o(chk_l), .check_remote_o(chk_r),
      .present_local_i(pl), .present_remote_i(pr), .id_err_i(ie), .sig_err_i(se),
      .bypass_local_i(bl), .bypass_remote_i(br), .ignore_local_i(il), .ignore_remote_i(ir)
   );

   typedef struct {
      int         idx;
      logic [3:0] f;      // {present, err, ignore, timeout}
   } exp_t;

   typedef struct {
      int         r;
      logic       lvl;
      logic       idv;
      logic       rem;
      logic [7:0] rf_res;
      logic [3:0] f;
      int         ngr;
   } vec_t;

   exp_t sb[$];
   vec_t vt[9];
   int   checks   = 0;
   int   failures = 0;
   int   grants   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] port_val(input int k);
      return {chk_l[k], chk_r[k], level[k], id[k]};
   endfunction

   function automatic logic [3:0] exp_port(input logic lvl, input logic idv, input logic rem);
      return {~rem, rem, lvl, idv};
   endfunction

   function automatic int pending(input int r);
      int n = 0;
      foreach (sb[j]) if (sb[j].idx == r) n++;
      return n;
   endfunction

   // Sampled at the falling edge: count grants, check port exclusivity, pop the scoreboard on handshakes
   task automatic monitor();
      for (int k = 0; k < N_PORTS; k++) begin
         if (chk_l[k] | chk_r[k]) begin
            grants++;
            chk($sformatf("port%0d_exclusive", k), 32'(chk_l[k] & chk_r[k]), 0);
         end
      end
      for (int i = 0; i < N_REQ; i++) begin
         if (rsp_valid[i] === 1'b1 && rsp_ready[i] === 1'b1) begin
            int found = -1;
            for (int j = 0; j < sb.size(); j++) begin
               if (found < 0 && sb[j].idx == i) found = j;
            end
            if (found < 0) begin
               chk($sformatf("unexpected_rsp%0d", i), 32'(rsp_valid[i]), 0);
            end else begin
               chk($sformatf("rsp%0d_fields", i),
                   {28'd0, rsp_present[i], rsp_err[i], rsp_ignore[i], rsp_timeout[i]}, 32'(sb[found].f));
               sb.delete(found);
            end
         end
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input int r, input int budget, output int cyc);
      cyc = 0;
      while (pending(r) > 0 && cyc < budget) begin
         cycle();
         cyc++;
      end
      if (pending(r) > 0) chk($sformatf("wait_rsp%0d_expired", r), 32'(pending(r)), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_req_ready"}, 32'(req_ready), 32'hF);
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
      chk({tag, "_rsp_fields"}, {16'd0, rsp_present, rsp_err, rsp_ignore, rsp_timeout}, 0);
      chk({tag, "_checks"}, {28'd0, chk_l, chk_r}, 0);
      chk({tag, "_level_id"}, {28'd0, level, id}, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
   endtask

   initial begin
      int cyc;
      rst        = 1'b1;
      req_valid  = '0;
      req_level  = '0;
      req_id     = '0;
      req_remote = '0;
      rsp_ready  = '1;
      rf_res     = '0;

      //           r  lvl   id    rem   rf_res       f        ngr
      vt[0] = '{0, 1'b0, 1'b1, 1'b0, 8'b1000_0000, 4'b1000, 1};
      vt[1] = '{1, 1'b1, 1'b0, 1'b0, 8'b0110_0000, 4'b0100, 1};
      vt[2] = '{3, 1'b0, 1'b1, 1'b1, 8'b0100_0001, 4'b1010, 1};
      vt[3] = '{2, 1'b1, 1'b1, 1'b1, 8'b0100_0100, 4'b0101, 4};
      vt[4] = '{0, 1'b0, 1'b0, 1'b0, 8'b0100_0110, 4'b0010, 1};
      vt[5] = '{1, 1'b1, 1'b1, 1'b1, 8'b1001_1000, 4'b0100, 1};
      vt[6] = '{3, 1'b0, 1'b0, 1'b0, 8'b1000_1000, 4'b0101, 4};
      vt[7] = '{2, 1'b0, 1'b1, 1'b1, 8'b0000_0000, 4'b0000, 1};
      vt[8] = '{0, 1'b1, 1'b0, 1'b0, 8'b1010_0010, 4'b1110, 1};

      cycle();
      cycle();
      check_reset_outputs("reset");
      rst = 1'b0;

      // Single-requester vectors: port drive, latency, grant count, response fields
      for (int v = 0; v < 9; v++) begin
         rf_res = vt[v].rf_res;
         req_valid[vt[v].r]  = 1'b1;
         req_level[vt[v].r]  = vt[v].lvl;
         req_id[vt[v].r]     = vt[v].idv;
         req_remote[vt[v].r] = vt[v].rem;
         sb.push_back('{vt[v].r, vt[v].f});
         grants = 0;
         cycle();
         req_valid = '0;
         chk($sformatf("v%0d_req_ready_low", v), 32'(req_ready[vt[v].r]), 0);
         chk($sformatf("v%0d_port0", v), 32'(port_val(0)), 32'(exp_port(vt[v].lvl, vt[v].idv, vt[v].rem)));
         chk($sformatf("v%0d_port1_idle", v), 32'(port_val(1)), 0);
         wait_done(vt[v].r, 20, cyc);
         chk($sformatf("v%0d_latency", v), 32'(cyc), 32'(vt[v].ngr + 1));
         chk($sformatf("v%0d_grants", v), 32'(grants), 32'(vt[v].ngr));
      end

      // Contention: all four at once from a fresh pointer
      do_reset();
      rf_res = 8'b1000_0000;
      for (int r = 0; r < N_REQ; r++) begin
         req_valid[r]  = 1'b1;
         req_level[r]  = 1'(r / 2);
         req_id[r]     = 1'(r % 2);
         req_remote[r] = 1'b0;
         sb.push_back('{r, 4'b1000});
      end
      cycle();
      req_valid = '0;
      chk("cont_c1_port0", 32'(port_val(0)), 32'(exp_port(1'b0, 1'b0, 1'b0)));
      chk("cont_c1_port1", 32'(port_val(1)), 32'(exp_port(1'b0, 1'b1, 1'b0)));
      cycle();
      chk("cont_c2_port0", 32'(port_val(0)), 32'(exp_port(1'b1, 1'b0, 1'b0)));
      chk("cont_c2_port1", 32'(port_val(1)), 32'(exp_port(1'b1, 1'b1, 1'b0)));
      cycle();
      chk("cont_c3_ports_idle", {28'd0, chk_l, chk_r}, 0);
      cycle();
      chk("cont_all_served", 32'(sb.size()), 0);

      // Pointer should be back at 0: requesters 1,2,3 get 1,2 first, then 3
      for (int r = 1; r < N_REQ; r++) begin
         req_valid[r] = 1'b1;
         sb.push_back('{r, 4'b1000});
      end
      cycle();
      req_valid = '0;
      chk("rr_c1_port0", 32'(port_val(0)), 32'(exp_port(1'b0, 1'b1, 1'b0)));
      chk("rr_c1_port1", 32'(port_val(1)), 32'(exp_port(1'b1, 1'b0, 1'b0)));
      cycle();
      chk("rr_c2_port0", 32'(port_val(0)), 32'(exp_port(1'b1, 1'b1, 1'b0)));
      chk("rr_c2_port1", 32'(port_val(1)), 0);
      cycle();
      cycle();
      chk("rr_all_served", 32'(sb.size()), 0);

      // Backpressure on requester 1 while requester 0 keeps going
      rf_res       = 8'b1000_0000;
      rsp_ready[1] = 1'b0;
      req_valid[1] = 1'b1; req_level[1] = 1'b1; req_id[1] = 1'b0; req_remote[1] = 1'b0;
      sb.push_back('{1, 4'b1000});
      cycle();
      req_valid = '0;
      cycle();
      chk("bp_rsp1_valid", 32'(rsp_valid[1]), 1);
      req_valid[0] = 1'b1; req_level[0] = 1'b0; req_id[0] = 1'b1; req_remote[0] = 1'b0;
      sb.push_back('{0, 4'b1000});
      for (int c = 0; c < 5; c++) begin
         cycle();
         req_valid = '0;
         chk($sformatf("bp_hold%0d", c),
             {28'd0, rsp_valid[1], req_ready[1], rsp_present[1], rsp_err[1] | rsp_ignore[1] | rsp_timeout[1]},
             32'b1010);
      end
      chk("bp_r0_served", 32'(pending(0)), 0);
      rsp_ready[1] = 1'b1;
      wait_done(1, 5, cyc);

      // Reset with requester 2 parked in RSP and 0,1 pending under bypass
      rsp_ready[2] = 1'b0;
      req_valid[2] = 1'b1; req_remote[2] = 1'b0;
      sb.push_back('{2, 4'b1000});
      cycle();
      req_valid = '0;
      cycle();
      chk("rst_r2_in_rsp", 32'(rsp_valid[2]), 1);
      rf_res = 8'b0000_1100;
      req_valid[0] = 1'b1;
      req_valid[1] = 1'b1;
      cycle();
      req_valid = '0;
      chk("rst_pre_ports_busy", {28'd0, chk_l, chk_r}, 32'b1100);
      rst = 1'b1;
      #1;
      chk("rst_ports_forced_off", {28'd0, chk_l, chk_r}, 0);
      cycle();
      rst = 1'b0;
      sb.delete();
      check_reset_outputs("midrst");
      rsp_ready = '1;
      rf_res    = '0;
      for (int c = 0; c < 6; c++) cycle();
      chk("midrst_no_grants", {28'd0, chk_l, chk_r}, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Hard stop in case a bounded wait is ever mis-sized
   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "global timeout");
   end

endmodule
